// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings, auto-refresh FSM states and default timing.
// Used by sdram_init, sdram_a_ref and the command arbiter.
package sdram_pkg;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;

    localparam int DEF_CNT_REF  = 750;
    localparam int DEF_TRP_CLK  = 2;
    localparam int DEF_TRFC_CLK = 7;

    typedef logic [2:0] aref_state_t;

    localparam aref_state_t ST_IDLE  = 3'd0;
    localparam aref_state_t ST_PRE   = 3'd1;
    localparam aref_state_t ST_TRP   = 3'd2;
    localparam aref_state_t ST_REF   = 3'd3;
    localparam aref_state_t ST_TRFC  = 3'd4;
    localparam aref_state_t ST_REF2  = 3'd5;
    localparam aref_state_t ST_TRFC2 = 3'd6;
    localparam aref_state_t ST_END   = 3'd7;

    function automatic logic [3:0] aref_cmd_of(input aref_state_t st);
        logic [3:0] cmd;
        cmd = CMD_NOP;
        if (st == ST_PRE)
            cmd = CMD_PRE;
        else if (st == ST_REF || st == ST_REF2)
            cmd = CMD_AREF;
        return cmd;
    endfunction

endpackage

// File: rtl/sdram_aref_timer.sv
// Refresh interval counter and aref_req set/clear logic.
// With SDRAM_AREF_DOUBLE_EN the interval doubles (11-bit counter) since each sequence refreshes twice.
module sdram_aref_timer
    import sdram_pkg::*;
#(
    parameter int CNT_REF = DEF_CNT_REF
) (
    input  logic clk,
    input  logic rstn,
    input  logic init_end,
    input  logic grant,
    output logic aref_req
);

`ifdef SDRAM_AREF_DOUBLE_EN
    localparam int CNT_W = 11;
    localparam int LIMIT = 2 * CNT_REF - 1;
`else
    localparam int CNT_W = 10;
    localparam int LIMIT = CNT_REF - 1;
`endif
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LIMIT);

    logic [CNT_W-1:0] cnt;

    // Counter saturates at CNT_MAX until granted, so a late grant delays the next request.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt      <= '0;
            aref_req <= 1'b0;
        end else if (!init_end) begin
            cnt <= '0;
        end else if (grant) begin
            cnt      <= '0;
            aref_req <= 1'b0;
        end else if (cnt == CNT_MAX) begin
            aref_req <= 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sdram_a_ref.sv
// Auto-refresh controller: PRECHARGE ALL then AUTO REFRESH with tRP/tRFC spacing on arbiter grant.
// Define SDRAM_AREF_DOUBLE_EN to issue two AUTO REFRESH commands per sequence.
module sdram_a_ref
    import sdram_pkg::*;
#(
    parameter int CNT_REF  = DEF_CNT_REF,
    parameter int TRP_CLK  = DEF_TRP_CLK,
    parameter int TRFC_CLK = DEF_TRFC_CLK
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        init_end,
    input  logic        aref_en,
    output logic        aref_req,
    output logic [3:0]  aref_cmd,
    output logic [1:0]  aref_bank,
    output logic [12:0] aref_addr,
    output logic        aref_end
);

    localparam logic [3:0] TRP_LAST  = 4'(TRP_CLK - 1);
    localparam logic [3:0] TRFC_LAST = 4'(TRFC_CLK - 1);

    aref_state_t state;
    aref_state_t state_nxt;
    logic [3:0]  cnt_clk;
    logic        grant;

    assign grant = aref_en & aref_req & init_end & (state == ST_IDLE);

    sdram_aref_timer #(
        .CNT_REF (CNT_REF)
    ) u_timer (
        .clk      (clk),
        .rstn     (rstn),
        .init_end (init_end),
        .grant    (grant),
        .aref_req (aref_req)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (grant) state_nxt = ST_PRE;
            ST_PRE:   state_nxt = ST_TRP;
            ST_TRP:   if (cnt_clk == TRP_LAST) state_nxt = ST_REF;
            ST_REF:   state_nxt = ST_TRFC;
`ifdef SDRAM_AREF_DOUBLE_EN
            ST_TRFC:  if (cnt_clk == TRFC_LAST) state_nxt = ST_REF2;
            ST_REF2:  state_nxt = ST_TRFC2;
            ST_TRFC2: if (cnt_clk == TRFC_LAST) state_nxt = ST_END;
`else
            ST_TRFC:  if (cnt_clk == TRFC_LAST) state_nxt = ST_END;
`endif
            ST_END:   state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state they belong to.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            cnt_clk   <= '0;
            aref_cmd  <= CMD_NOP;
            aref_bank <= 2'b11;
            aref_addr <= 13'h1FFF;
            aref_end  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt_clk   <= (state_nxt != state) ? 4'd0 : cnt_clk + 4'd1;
            aref_cmd  <= aref_cmd_of(state_nxt);
            aref_bank <= 2'b11;
            aref_addr <= 13'h1FFF;
            aref_end  <= (state_nxt == ST_END);
        end
    end

endmodule
